mem_store_unit: RTL

- Write-side counterpart to the datapath's memory-data capture register. It takes one store request per handshake from the CPU core and drives the data-memory write port.
- Each request carries an address, data and a size. The block aligns and replicates the data, generates byte strobes and checks alignment.
- It holds the memory write request until the memory acknowledges, or until a timeout expires.
- It sits between the execute/memory stage and the data memory.

---
 rtl/cpu_mem_pkg.sv | 15 +
 rtl/store_align.sv | 48 ++++
 rtl/mem_store_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the CPU data-memory path (store side, later load side).
package cpu_mem_pkg;

  // Access size as carried on st_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Store unit control state
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

endpackage

// File: rtl/store_align.sv
// Combinational store formatter: replicates data across byte lanes, builds
// the lane strobes and flags misaligned or reserved-size accesses.
module store_align
  import cpu_mem_pkg::*;
(
  input  logic [1:0]  st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        misalign
);

  // One-hot lane select for byte accesses, one bit per byte lane
  logic [3:0] lane_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_sel[gi] = (st_addr == 2'(gi));
  end

  // Size-dependent replication, strobes and alignment check
  always_comb begin
    wdata    = '0;
    wstrb    = '0;
    misalign = 1'b0;
    case (st_size)
      SZ_BYTE: begin
        wdata = {4{st_data[7:0]}};
        wstrb = lane_sel;
      end
      SZ_HALF: begin
        wdata    = {2{st_data[15:0]}};
        wstrb    = st_addr[1] ? 4'b1100 : 4'b0011;
        misalign = st_addr[0];
      end
      SZ_WORD: begin
        wdata    = st_data;
        wstrb    = 4'b1111;
        misalign = |st_addr;
      end
      default: begin
        // Reserved size: always rejected, lanes left quiet
        misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_store_unit.sv
// Store unit: accepts one store per handshake, holds a registered write
// request on the data-memory port until ack or timeout, reports status pulses.
module mem_store_unit
  import cpu_mem_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  output logic        done,
  output logic        misalign_err,
  output logic        timeout_err
);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next, cnt_inc;
  logic               we_reg, we_next;
  logic [31:0]        addr_reg, addr_next;
  logic [31:0]        wdata_reg, wdata_next;
  logic [3:0]         wstrb_reg, wstrb_next;
  logic               done_reg, done_next;
  logic               mis_reg, mis_next;
  logic               to_reg, to_next;

  logic [31:0]        al_wdata;
  logic [3:0]         al_wstrb;
  logic               al_misalign;

  store_align u_align (
    .st_addr  (st_addr[1:0]),
    .st_data  (st_data),
    .st_size  (st_size),
    .wdata    (al_wdata),
    .wstrb    (al_wstrb),
    .misalign (al_misalign)
  );

  // Wait counter value after one more un-acked WRITE cycle
  always_comb cnt_inc = cnt_reg + CNT_W'(1);

  // Next-state and next-output logic; status pulses default to 0 so they
  // last exactly one cycle
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    wstrb_next = wstrb_reg;
    done_next  = 1'b0;
    mis_next   = 1'b0;
    to_next    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (st_valid) begin
          if (al_misalign) begin
            mis_next = 1'b1;
          end else begin
            addr_next  = {st_addr[31:2], 2'b00};
            wdata_next = al_wdata;
            wstrb_next = al_wstrb;
            we_next    = 1'b1;
            cnt_next   = '0;
            state_next = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          we_next    = 1'b0;
          wstrb_next = '0;
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_W'(TIMEOUT)) begin
            we_next    = 1'b0;
            wstrb_next = '0;
            to_next    = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, counter and registered memory-port outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
      done_reg  <= 1'b0;
      mis_reg   <= 1'b0;
      to_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      wstrb_reg <= wstrb_next;
      done_reg  <= done_next;
      mis_reg   <= mis_next;
      to_reg    <= to_next;
    end
  end

  assign st_ready     = (state_reg == ST_IDLE);
  assign mem_we       = we_reg;
  assign mem_addr     = addr_reg;
  assign mem_wdata    = wdata_reg;
  assign mem_wstrb    = wstrb_reg;
  assign done         = done_reg;
  assign misalign_err = mis_reg;
  assign timeout_err  = to_reg;

endmodule
